fir_tree_sequencer: RTL and testbench

//  Time-multiplexes one shared N-input signed adder tree to reduce a TAPS-wide product vector.

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_sat_add.sv | 38 +++
 rtl/fir_tree_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fir_tree_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared word type, sequencer state encoding and saturation limits
// for the FIR adder-tree sequencer and its accumulate adder.
// Latency/backpressure: n/a (types and constants only).
package fir_pkg;

  typedef logic signed [31:0] fir_word_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam fir_word_t FIR_WORD_MAX = 32'sh7FFF_FFFF;
  localparam fir_word_t FIR_WORD_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fir_sat_add.sv
// fir_sat_add: two-input 32-bit signed adder used for the accumulate step.
// Latency: combinational. Backpressure: none.
// Build option FIR_SEQ_SAT_EN: result clamps to [FIR_WORD_MIN, FIR_WORD_MAX] and
// ovf reports the clamp; without it the add wraps and the ovf port is absent.
// Ports: a, b operands; sum result; ovf clamp indicator (saturating build only).
module fir_sat_add
  import fir_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
`ifdef FIR_SEQ_SAT_EN
  output logic               ovf,
`endif
  output logic signed [31:0] sum
);

`ifdef FIR_SEQ_SAT_EN
  logic [32:0] wide;

  always_comb begin
    wide = {a[31], a} + {b[31], b};
    // Overflow when the carry-out sign disagrees with the 32-bit sign.
    ovf  = (wide[32] != wide[31]);
    if (!ovf) begin
      sum = wide[31:0];
    end else if (wide[32]) begin
      sum = FIR_WORD_MIN;
    end else begin
      sum = FIR_WORD_MAX;
    end
  end
`else
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

// File: rtl/fir_tree_sequencer.sv
// fir_tree_sequencer: reduces a TAPS-wide signed product vector through one shared
// external N-input adder tree, PASSES=ceil(TAPS/N) chunks, accumulating partial sums.
// Latency: out_valid rises PASSES edges after the accept edge; one vector in flight.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
// Build option FIR_SEQ_SAT_EN: saturating accumulate with sticky per-vector out_sat.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_prod (TAPS x 32, lane k at
// [k*32 +: 32]); tree_in (N x 32, same packing) / tree_sum to the external tree;
// out_valid/out_ready/out_sum/out_sat result handshake; busy = not IDLE.
module fir_tree_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = 32,
  parameter int N    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*32-1:0]     in_prod,
  output logic [N*32-1:0]        tree_in,
  input  logic signed [31:0]     tree_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [31:0]     out_sum,
  output logic                   out_sat,
  output logic                   busy
);

  localparam int PASSES = (TAPS + N - 1) / N;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  seq_state_t        state_q, state_d;
  logic [PW-1:0]     p_q, p_d;
  fir_word_t         acc_q, acc_d;
  fir_word_t         out_sum_q, out_sum_d;
  logic [TAPS*32-1:0] prod_q, prod_d;

  fir_word_t         add_sum;
  fir_word_t         acc_next;
  logic              first_pass;
  logic              last_pass;

  assign first_pass = (p_q == '0);
  assign last_pass  = (p_q == PW'(PASSES - 1));

`ifdef FIR_SEQ_SAT_EN
  logic add_ovf;
  logic sat_q, sat_d;
  logic out_sat_q, out_sat_d;
  logic sat_next;

  fir_sat_add u_acc_add (
    .a   (acc_q),
    .b   (tree_sum),
    .ovf (add_ovf),
    .sum (add_sum)
  );

  // The first pass loads tree_sum directly, so it can never clamp.
  assign sat_next = first_pass ? 1'b0 : (sat_q | add_ovf);
`else
  fir_sat_add u_acc_add (
    .a   (acc_q),
    .b   (tree_sum),
    .sum (add_sum)
  );
`endif

  assign acc_next = first_pass ? tree_sum : add_sum;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    prod_d    = prod_q;
`ifdef FIR_SEQ_SAT_EN
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          prod_d  = in_prod;
          p_d     = '0;
`ifdef FIR_SEQ_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        acc_d = acc_next;
`ifdef FIR_SEQ_SAT_EN
        sat_d = sat_next;
`endif
        if (last_pass) begin
          out_sum_d = acc_next;
`ifdef FIR_SEQ_SAT_EN
          out_sat_d = sat_next;
`endif
          state_d   = SEQ_DONE;
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      SEQ_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Tree operands: chunk p of the latched vector, zero-padded past TAPS; zeros when not running.
  always_comb begin
    tree_in = '0;
    if (state_q == SEQ_RUN) begin
      for (int i = 0; i < N; i++) begin
        if (int'(p_q) * N + i < TAPS) begin
          tree_in[i*32 +: 32] = prod_q[(int'(p_q) * N + i) * 32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      p_q       <= '0;
      acc_q     <= '0;
      out_sum_q <= '0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      out_sum_q <= out_sum_d;
      prod_q    <= prod_d;
    end
  end

`ifdef FIR_SEQ_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_sat = out_sat_q;
`else
  assign out_sat = 1'b0;
`endif

  assign out_sum = out_sum_q;
  assign busy    = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_fir_tree_sequencer.sv
// tb_fir_tree_sequencer: directed bench for three sequencer configurations
// (32/8, 10/4, 8/1), each paired with a wrapping combinational adder-tree model.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_fir_tree_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Instance A: TAPS=32, N=8 (4 passes)
  logic          in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1, out_sat_a, busy_a;
  logic [1023:0] in_prod_a = '0;
  logic [255:0]  tree_in_a;
  logic [31:0]   tree_sum_a, out_sum_a;

  // Instance B: TAPS=10, N=4 (3 passes)
  logic          in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, out_sat_b, busy_b;
  logic [319:0]  in_prod_b = '0;
  logic [127:0]  tree_in_b;
  logic [31:0]   tree_sum_b, out_sum_b;

  // Instance C: TAPS=8, N=1 (8 passes) -- one product per pass, so every
  // pass after the first goes through the accumulate adder and can clamp.
  logic          in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1, out_sat_c, busy_c;
  logic [255:0]  in_prod_c = '0;
  logic [31:0]   tree_in_c;
  logic [31:0]   tree_sum_c, out_sum_c;

  fir_tree_sequencer #(.TAPS(32), .N(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_prod(in_prod_a),
    .tree_in(tree_in_a), .tree_sum(tree_sum_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_sum(out_sum_a), .out_sat(out_sat_a), .busy(busy_a));

  fir_tree_sequencer #(.TAPS(10), .N(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_prod(in_prod_b),
    .tree_in(tree_in_b), .tree_sum(tree_sum_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_sum(out_sum_b), .out_sat(out_sat_b), .busy(busy_b));

  fir_tree_sequencer #(.TAPS(8), .N(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_prod(in_prod_c),
    .tree_in(tree_in_c), .tree_sum(tree_sum_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out_sum(out_sum_c), .out_sat(out_sat_c), .busy(busy_c));

  // Shared adder-tree models: plain wrapping sums of the operand lanes.
  always_comb begin
    tree_sum_a = '0;
    for (int i = 0; i < 8; i++) tree_sum_a = tree_sum_a + tree_in_a[i*32 +: 32];
  end
  always_comb begin
    tree_sum_b = '0;
    for (int i = 0; i < 4; i++) tree_sum_b = tree_sum_b + tree_in_b[i*32 +: 32];
  end
  always_comb begin
    tree_sum_c = tree_in_c;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector through instance C: in_prod[k] = base + k*step.
  task automatic run_c(input string tag, input logic [31:0] base, input logic [31:0] step,
                       input logic [31:0] exp_sum, input logic exp_sat);
    for (int k = 0; k < 8; k++) in_prod_c[k*32 +: 32] = base + step * 32'(k);
    in_valid_c  = 1'b1;
    out_ready_c = 1'b1;
    tick();
    in_valid_c = 1'b0;
    repeat (7) tick();
    check_val({tag, "_vld_early"}, 32'(out_valid_c), 32'd0);
    tick();
    check_val({tag, "_vld"}, 32'(out_valid_c), 32'd1);
    check_val({tag, "_sum"}, out_sum_c, exp_sum);
    check_val({tag, "_sat"}, 32'(out_sat_c), 32'(exp_sat));
    tick();
    check_val({tag, "_vld_drop"}, 32'(out_valid_c), 32'd0);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] vec_sum;
  logic        seen_vld;

  task automatic load_random_a();
    vec_sum = '0;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] v;
      v = 32'($urandom_range(0, 200000)) - 32'd100000;
      in_prod_a[k*32 +: 32] = v;
      vec_sum = vec_sum + v;
    end
  endtask

  initial begin
    int n_acc, n_out, last_acc;
    logic acc_now;

    // Reset state
    tick();
    tick();
    check_val("rst_in_ready", 32'(in_ready_a), 32'd1);
    check_val("rst_out_valid", 32'(out_valid_a), 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_out_sum", out_sum_a, 32'd0);
    check_val("rst_out_sat", 32'(out_sat_a), 32'd0);
    check_val("rst_tree_in", 32'(|tree_in_a), 32'd0);
    rst = 1'b0;
    tick();
    check_val("idle_in_ready_b", 32'(in_ready_b), 32'd1);

    // 1: ramp 1..32 through A, sum 528, out_valid 4 edges after accept, 1 cycle wide
    for (int k = 0; k < 32; k++) in_prod_a[k*32 +: 32] = 32'(k + 1);
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    check_val("t1_busy", 32'(busy_a), 32'd1);
    check_val("t1_in_ready", 32'(in_ready_a), 32'd0);
    check_val("t1_tree_lane0", tree_in_a[31:0], 32'd1);
    repeat (3) tick();
    check_val("t1_vld_early", 32'(out_valid_a), 32'd0);
    tick();
    check_val("t1_vld", 32'(out_valid_a), 32'd1);
    check_val("t1_sum", out_sum_a, 32'd528);
    check_val("t1_tree_idle", 32'(|tree_in_a), 32'd0);
    tick();
    check_val("t1_vld_drop", 32'(out_valid_a), 32'd0);
    check_val("t1_in_ready_back", 32'(in_ready_a), 32'd1);

    // 2+3: B all ones, last chunk zero-padded, then held result under backpressure
    for (int k = 0; k < 10; k++) in_prod_b[k*32 +: 32] = 32'd1;
    in_valid_b  = 1'b1;
    out_ready_b = 1'b0;
    tick();
    // New data presented while busy must be ignored until the next accept.
    for (int k = 0; k < 10; k++) in_prod_b[k*32 +: 32] = 32'd2;
    check_val("t2_latched", tree_in_b[31:0], 32'd1);
    tick();
    tick();
    check_val("t2_p2_lane0", tree_in_b[31:0], 32'd1);
    check_val("t2_p2_lane1", tree_in_b[63:32], 32'd1);
    check_val("t2_p2_lane2", tree_in_b[95:64], 32'd0);
    check_val("t2_p2_lane3", tree_in_b[127:96], 32'd0);
    tick();
    check_val("t2_vld", 32'(out_valid_b), 32'd1);
    check_val("t2_sum", out_sum_b, 32'd10);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("t3_hold_vld", 32'(out_valid_b), 32'd1);
      check_val("t3_hold_sum", out_sum_b, 32'd10);
      check_val("t3_hold_in_ready", 32'(in_ready_b), 32'd0);
    end
    out_ready_b = 1'b1;
    tick();
    check_val("t3_release_vld", 32'(out_valid_b), 32'd0);
    check_val("t3_release_in_ready", 32'(in_ready_b), 32'd1);
    tick();
    in_valid_b = 1'b0;
    check_val("t3_next_accept", 32'(busy_b), 32'd1);
    repeat (3) tick();
    check_val("t3_next_vld", 32'(out_valid_b), 32'd1);
    check_val("t3_next_sum", out_sum_b, 32'd20);
    tick();

    // 4: reset during pass 1 of A discards the vector
    for (int k = 0; k < 32; k++) in_prod_a[k*32 +: 32] = 32'(k + 1);
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    tick();
    check_val("t4_pass1_lane0", tree_in_a[31:0], 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t4_in_ready", 32'(in_ready_a), 32'd1);
    check_val("t4_busy", 32'(busy_a), 32'd0);
    check_val("t4_tree_zero", 32'(|tree_in_a), 32'd0);
    seen_vld = out_valid_a;
    repeat (6) begin
      tick();
      seen_vld = seen_vld | out_valid_a;
    end
    check_val("t4_no_vld", 32'(seen_vld), 32'd0);

    // 5: overflow handling on C
`ifdef FIR_SEQ_SAT_EN
    run_c("t5_max", 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 1'b1);
    run_c("t5_min", 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b1);
`else
    run_c("t5_max", 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFF8, 1'b0);
    run_c("t5_min", 32'h8000_0000, 32'd0, 32'h0000_0000, 1'b0);
`endif
    // -3..4 sums to 4; sticky flag from the previous vector must be cleared.
    run_c("t5_small", 32'hFFFF_FFFD, 32'd1, 32'd4, 1'b0);

    // 6: back-to-back on A; accept edges are PASSES+2 = 6 apart
    // (IDLE, four RUN cycles, DONE: five non-accepting cycles in between).
    load_random_a();
    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    n_acc = 0;
    n_out = 0;
    last_acc = -1;
    for (int cyc = 0; cyc < 40 && n_out < 3; cyc++) begin
      acc_now = in_valid_a && in_ready_a;
      if (acc_now) begin
        if (last_acc >= 0) check_val("t6_gap", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        exp_q.push_back(vec_sum);
        n_acc++;
      end
      if (out_valid_a) begin
        check_val("t6_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_val("t6_sum", out_sum_a, exp_q.pop_front());
        n_out++;
      end
      tick();
      if (acc_now) begin
        if (n_acc < 3) load_random_a();
        else in_valid_a = 1'b0;
      end
    end
    check_val("t6_out_count", 32'(n_out), 32'd3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
